// File: rtl/cpu_mem_dma_pkg.sv
// Shared types and constants for the on-chip memory bulk loader/readback DMA.
// The state enum is shared by the engine and anything that observes it.
package cpu_mem_dma_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
  } state_t;

endpackage

// File: rtl/cpu_mem_dma_rdfifo.sv
// Two-entry readback FIFO between the memory read port and the dump stream.
// The flush clears occupancy so late read returns can be discarded cleanly.
module cpu_mem_dma_rdfifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot [2];
  logic              wr_sel;
  logic              rd_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_sel] <= push_data;
        wr_sel       <= ~wr_sel;
      end
      if (pop) rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = slot[rd_sel];

endmodule

// File: rtl/cpu_mem_dma.sv
// Avalon-MM master filling or dumping a contiguous word range of CPU memory
// from/to a pair of valid/ready streams.
module cpu_mem_dma #(
  parameter int ADDR_W = cpu_mem_dma_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_dma_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  import cpu_mem_dma_pkg::*;

  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   to_issue;
  logic              pend;
  logic [1:0]        fcount;
  logic              wr_fire;
  logic              rd_issue;
  logic              pop;
  logic [2:0]        occ;
  logic [2:0]        lim;

  assign cmd_ready = (state == S_IDLE) && !abort;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) && !abort;
  assign in_ready  = (state == S_WR) && !abort;
  assign wr_fire   = in_ready && in_valid;
  assign pop       = out_valid && out_ready;

  // Occupancy includes the read still on the bus; a pop this cycle frees a slot.
  assign occ      = {1'b0, fcount} + {2'b00, pend};
  assign lim      = 3'd2 + {2'b00, pop};
  assign rd_issue = (state == S_RD) && !abort
                    && (to_issue != '0) && (occ < lim);

  assign mem_chipselect = wr_fire || rd_issue;
  assign mem_write      = wr_fire;
  assign mem_writedata  = in_data;
  assign mem_byteenable = '1;
  assign mem_address    = (state == S_WR || state == S_RD) ? ptr : '0;

  assign out_valid = (fcount != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      to_issue  <= '0;
      pend      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      to_issue  <= '0;
      pend      <= 1'b0;
    end else begin
      pend <= rd_issue;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            ptr       <= cmd_addr;
            remaining <= cmd_len;
            to_issue  <= cmd_len;
            state     <= (cmd_len == '0) ? S_DONE :
                         (cmd_write ? S_WR : S_RD);
          end
        end
        S_WR: begin
          if (in_valid) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= S_DONE;
          end
        end
        S_RD: begin
          if (rd_issue) begin
            ptr      <= ptr + PTR_ONE;
            to_issue <= to_issue - LEN_ONE;
          end
          if (pop) begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  cpu_mem_dma_rdfifo #(
    .DATA_W (DATA_W)
  ) u_rdfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (pend),
    .push_data (mem_readdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fcount)
  );

endmodule

// File: tb/tb_cpu_mem_dma.sv
// Directed plus randomized bench for cpu_mem_dma against a word-array model
// of memory contents and the expected stream/timing behaviour.
module tb_cpu_mem_dma;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW/8-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  cpu_mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  // Slave memory with one-cycle read latency
  logic [DW-1:0] smem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) smem[mem_address] <= mem_writedata;
      else           mem_readdata      <= smem[mem_address];
    end
  end

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] fdata [$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            wr_cyc_q  [$];
  logic [DW-1:0] pop_q     [$];
  int            pop_cyc_q [$];
  int            done_q    [$];
  int            cs_cnt = 0;
  int            rd_iss = 0;
  int            rd_pop = 0;
  int            max_out = 0;
  int            stab_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      rd_iss = 0;
      rd_pop = 0;
      prev_stall = 1'b0;
    end else begin
      if (mem_chipselect) cs_cnt++;
      if (mem_chipselect && mem_write) begin
        wr_addr_q.push_back(mem_address);
        wr_data_q.push_back(mem_writedata);
        wr_cyc_q.push_back(cyc);
      end
      if (mem_chipselect && !mem_write) rd_iss++;
      if (done) done_q.push_back(cyc);
      if (prev_stall && !(out_valid && out_data === prev_data)) stab_err++;
      if (out_valid && out_ready) begin
        pop_q.push_back(out_data);
        pop_cyc_q.push_back(cyc);
        rd_pop++;
      end
      if (rd_iss - rd_pop > max_out) max_out = rd_iss - rd_pop;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (abort) begin
        rd_iss = 0;
        rd_pop = 0;
        prev_stall = 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {cmd_ready, busy, done, in_ready, out_valid,
              mem_chipselect, mem_write, mem_address},
        {7'b1000000, 13'h0000});
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input int abort_at,
                         input bit hold);
    int n, k, t, c0, wb, db;
    bit fin;
    logic [AW-1:0] ea;
    n = fdata.size();
    k = 0;
    t = 0;
    fin = 1'b0;
    wb = wr_addr_q.size();
    db = done_q.size();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_len   = n[AW:0];
    #1;
    chk("fill_cmd_ready", cmd_ready, 1);
    c0 = cyc;
    while (!fin && t < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      t++;
      abort    = (t == abort_at);
      in_valid = (k < n) && (hold || $urandom_range(0, 1) == 1);
      in_data  = (k < n) ? fdata[k] : '0;
      #1;
      if (in_valid && in_ready) k++;
      fin = abort || done;
    end
    if (!fin) chk("fill_timeout", 0, 1);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fill_idle", {cmd_ready, busy, in_ready}, 3'b100);
    if (abort_at == 0) begin
      chk("fill_nwr", wr_addr_q.size() - wb, n);
      for (int i = 0; i < n && wb + i < wr_addr_q.size(); i++) begin
        ea = a + i[AW-1:0];
        chk("fill_addr", wr_addr_q[wb+i], ea);
        chk("fill_data", wr_data_q[wb+i], fdata[i]);
        if (hold) chk("fill_wr_cyc", wr_cyc_q[wb+i], c0 + 1 + i);
        ref_mem[ea] = fdata[i];
      end
      chk("fill_ndone", done_q.size() - db, 1);
      if (hold && done_q.size() > db)
        chk("fill_done_cyc", done_q[db], c0 + n + 1);
    end else begin
      chk("abort_fill_nwr", wr_addr_q.size() - wb, abort_at - 1);
      chk("abort_fill_ndone", done_q.size() - db, 0);
      for (int i = 0; i < abort_at - 1; i++) begin
        ea = a + i[AW-1:0];
        ref_mem[ea] = fdata[i];
      end
    end
  endtask

  task automatic do_dump(input logic [AW-1:0] a, input int n,
                         input int mode, input int abort_at);
    int t, c0, pb, db;
    bit fin;
    logic [AW-1:0] ea;
    t = 0;
    fin = 1'b0;
    pb = pop_q.size();
    db = done_q.size();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_len   = n[AW:0];
    #1;
    chk("dump_cmd_ready", cmd_ready, 1);
    c0 = cyc;
    while (!fin && t < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      t++;
      abort = (t == abort_at);
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = (t % 4 == 1) || (t % 4 == 0);
      else                out_ready = ($urandom_range(0, 1) == 1);
      #1;
      fin = abort || done;
    end
    if (!fin) chk("dump_timeout", 0, 1);
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("dump_idle", {cmd_ready, busy, out_valid}, 3'b100);
    if (abort_at == 0) begin
      chk("dump_npop", pop_q.size() - pb, n);
      for (int i = 0; i < n && pb + i < pop_q.size(); i++) begin
        ea = a + i[AW-1:0];
        chk("dump_data", pop_q[pb+i], ref_mem[ea]);
      end
      chk("dump_ndone", done_q.size() - db, 1);
      if (mode == 0 && done_q.size() > db && pop_q.size() > pb) begin
        chk("dump_first_pop_cyc", pop_cyc_q[pb], c0 + 3);
        chk("dump_done_cyc", done_q[db], c0 + n + 3);
      end
    end else begin
      chk("abort_dump_ndone", done_q.size() - db, 0);
      @(negedge clk);
      #1;
      chk("abort_dump_out_valid", out_valid, 0);
    end
    chk("max_outstanding", max_out <= 2, 1);
    chk("stall_stable", stab_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cb, db, c0, n;
    logic [AW-1:0] a;

    repeat (2) @(negedge clk);
    #1;
    chk_reset("reset_vals");
    chk("byteenable", mem_byteenable, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_reset("post_reset_vals");

    fdata = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_fill(13'h0010, 0, 1'b1);

    fdata = {32'h11, 32'h22, 32'h33, 32'h44};
    do_fill(13'h1FFE, 0, 1'b1);
    do_dump(13'h1FFE, 4, 0, 0);

    fdata = {};
    for (int i = 0; i < 8; i++) fdata.push_back($urandom);
    do_fill(13'h0200, 0, 1'b0);
    do_dump(13'h0200, 8, 1, 0);

    cb = cs_cnt;
    db = done_q.size();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = ($urandom_range(0, 1) == 1);
    cmd_len   = '0;
    #1;
    c0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("len0_done", done, 1);
    @(negedge clk);
    #1;
    chk("len0_idle", cmd_ready, 1);
    chk("len0_no_cs", cs_cnt - cb, 0);
    if (done_q.size() > db) chk("len0_done_cyc", done_q[db], c0 + 1);
    else chk("len0_ndone", done_q.size() - db, 1);

    fdata = {};
    for (int i = 0; i < 8; i++) fdata.push_back($urandom);
    do_fill(13'h0100, 3, 1'b1);

    do_dump(13'h0200, 8, 0, 3);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_len   = 14'd5;
    abort     = 1'b1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #1;
    chk("abort_cmd_busy", busy, 0);

    for (int r = 0; r < 3; r++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      n = $urandom_range(1, 12);
      fdata = {};
      for (int i = 0; i < n; i++) fdata.push_back($urandom);
      do_fill(a, 0, 1'b0);
      do_dump(a, n, 2, 0);
    end

    fdata = {};
    for (int i = 0; i < 8; i++) fdata.push_back($urandom);
    do_fill(13'h0400, 0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 13'h0400;
    cmd_len   = 14'd8;
    repeat (4) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      out_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    reset_n   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_reset("mid_dump_reset");
    @(negedge clk);
    reset_n = 1'b1;
    do_dump(13'h0400, 8, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_dma.md
# cpu_mem_dma

Avalon-MM master that moves 32-bit words between streaming ports and the CPU on-chip memory's data port (8192 × 32, single-port, byteenable). A command selects a fill (stream → memory) or a dump (memory → stream) of a contiguous word range. It sits beside the Nios CPU as the bulk loader/readback engine, used for firmware download and memory inspection over the debug link.

## Interface
- `ADDR_W`, 13, word-address width; the memory holds 2^ADDR_W words.
- `DATA_W`, 32, word width; byteenable width is DATA_W/8.
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when both are high.
- `cmd_write` input 1: 1 = fill (stream → memory); 0 = dump (memory → stream).
- `cmd_addr` input ADDR_W: start word address.
- `cmd_len` input ADDR_W+1: word count, 0..2^ADDR_W.
- `abort` input 1: synchronous cancel.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when a command completes.
- `in_valid`, `in_ready`, `in_data[DATA_W]`: fill stream (input, output, input).
- `out_valid`, `out_ready`, `out_data[DATA_W]`: dump stream (output, input, output).
- `mem_address` output ADDR_W: word address.
- `mem_chipselect`, `mem_write` output 1: access strobes.
- `mem_byteenable` output DATA_W/8: always all-ones.
- `mem_writedata` output DATA_W: write data.
- `mem_readdata` input DATA_W: read data, fixed read latency of 1; no waitrequest.

## Operation
- States: IDLE, WR, RD, DONE.
- `cmd_ready` = (IDLE && !abort).
- On accept: latch `ptr` = `cmd_addr` and `remaining` = `cmd_len`.
  - `cmd_len` = 0: go to DONE.
  - Otherwise: go to WR if `cmd_write`, else RD.
- WR:
  - `in_ready` = 1.
  - `mem_chipselect` = `mem_write` = `in_valid`; `mem_writedata` = `in_data`; `mem_address` = `ptr`. This path is combinational: one word per cycle.
  - Each transfer increments `ptr` modulo 2^ADDR_W (wraps 8191 → 0) and decrements `remaining`.
  - Last transfer → DONE.
- RD:
  - Reads are issued with `mem_chipselect` = 1, `mem_write` = 0, `mem_address` = `ptr`.
  - `mem_readdata` is captured into a 2-entry output FIFO on the cycle after issue.
  - A read is issued when `issued` < `cmd_len` and fifo_count + inflight − pop < 2, where pop = `out_valid && out_ready`.
  - `ptr` wraps as in WR.
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - Leave for DONE on the pop of the last word.
- DONE: `done` = 1 for one cycle, then IDLE.
- `abort` (any state):
  - Next state is IDLE; FIFO, inflight, counters cleared; no `done` pulse.
  - Writes already performed stay in memory.
  - An in-flight read that returns after abort is discarded.
  - `abort` together with `cmd_valid` in IDLE: the command is not accepted.
- Outside WR: `in_ready` = 0. Outside RD: no reads are issued, and `out_valid` = 0 except while the FIFO drains.
- `mem_chipselect` = 0 whenever no access is issued that cycle.

## Timing
- Reset values: state IDLE, FIFO empty, all counters 0.
  - Outputs: `cmd_ready` 1, `busy` 0, `done` 0, `in_ready` 0, `out_valid` 0, `mem_chipselect` 0, `mem_write` 0, `mem_address` 0.
  - `mem_byteenable` is always all-ones.
- Command accepted in cycle 0 → WR or RD is entered in cycle 1.
- Fill of N words with `in_valid` held high: writes in cycles 1..N, `done` in cycle N+1, `cmd_ready` high again in cycle N+2.
- Dump: first read issued in cycle 1; data captured at the end of cycle 2; `out_valid` first high in cycle 3.
  - With `out_ready` held high: 1 word/cycle, last word popped in cycle N+2, `done` in cycle N+3.
- `out_ready` low: at most 2 reads are outstanding; `out_data` is stable while `out_valid && !out_ready`.
- `cmd_len` = 0: `done` in cycle 1.

## Structure
- Shared package `cpu_mem_dma_pkg`: state enum; constants for MEM_WORDS = 8192, ADDR_W, DATA_W.
- One sub-module, `cpu_mem_dma_rdfifo`: 2-entry FIFO with count output and synchronous flush.

## Test plan
- Fill 4 words (`cmd_addr` 0x0010, data 0xA0..0xA3), `in_valid` held high → writes at 0x10..0x13 in cycles 1–4, `done` in cycle 5, `busy` low in cycle 6.
- Dump 4 words from 0x1FFE after preloading 0x11, 0x22, 0x33, 0x44 at 0x1FFE, 0x1FFF, 0x0000, 0x0001 → `out_data` sequence 0x11, 0x22, 0x33, 0x44 (wrap-around).
- Dump 8 words with `out_ready` toggling 1-0-0-1 → no word lost or duplicated, never more than 2 outstanding reads, `out_data` stable while stalled.
- `cmd_len` = 0 → `done` in cycle 1, no `mem_chipselect` activity.
- `abort` in cycle 3 of an 8-word fill → exactly 2 writes performed, no `done`, `cmd_ready` high the next cycle. The same abort during a dump leaves `out_valid` low afterwards.
- Assert `reset_n` low mid-dump → all outputs at reset values immediately; a new command after release completes normally.
